// File: rtl/prbs_pkg.sv
// prbs_pkg: shared constants and types for the PRBS generator/checker.
//   LFSR_W / WORD_W  : LFSR state width and stream word width.
//   TAP_*            : feedback taps of the 16-bit Fibonacci LFSR
//                      (x^16 + x^14 + x^13 + x^11 + 1, XNOR form).
//   LOCKUP           : the one state an XNOR LFSR can never leave.
//   chk_state_e      : checker FSM states.
package prbs_pkg;

  localparam int LFSR_W = 16;
  localparam int WORD_W = 8;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [LFSR_W-1:0] LOCKUP = 16'hFFFF;

  typedef enum logic [1:0] {
    SEARCH0 = 2'd0,
    SEARCH1 = 2'd1,
    LOCKED  = 2'd2
  } chk_state_e;

endpackage

// File: rtl/prbs_step8.sv
// prbs_step8: purely combinational 8-step advance of the XNOR LFSR.
//   state_i : current 16-bit LFSR state
//   state_o : state after WORD_W steps; its low byte is the generated word,
//             with the first new bit at bit 7.
module prbs_step8
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  // One stage per bit; each stage shifts left and appends the XNOR of the taps.
  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_step
    logic [LFSR_W-1:0] prev;
    logic [LFSR_W-1:0] s;
    if (gi == 0) begin : g_first
      assign prev = state_i;
    end else begin : g_rest
      assign prev = g_step[gi-1].s;
    end
    assign s = {prev[LFSR_W-2:0], ~(prev[TAP_A] ^ prev[TAP_B] ^ prev[TAP_C] ^ prev[TAP_D])};
  end

  assign state_o = g_step[WORD_W-1].s;

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: PRBS word generator plus self-synchronising checker.
//   CK, RST          : clock (rising edge) and synchronous active-high reset
//   EN, LOAD, SEED   : generator enable, one-cycle seed load, seed value
//   out_valid/out_ready/out_data : generator output stream
//   in_valid/in_ready/in_data    : checker input stream (in_ready = 1 out of reset)
//   locked           : checker is in LOCKED
//   err_cnt          : saturating count of mismatched words (cleared by RST only)
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              EN,
  input  logic              LOAD,
  input  logic [LFSR_W-1:0] SEED,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              locked,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

  // ---------------- generator ----------------
  logic [LFSR_W-1:0] gen_state_q, gen_state_d;
  logic [WORD_W-1:0] gen_data_q;
  logic              gen_valid_q;
  logic              gen_take;

  prbs_step8 u_gen_step (
    .state_i (gen_state_q),
    .state_o (gen_state_d)
  );

  // A new word is produced when enabled and the output slot is empty or
  // being emptied this edge, giving one word per cycle under back-to-back ready.
  assign gen_take = EN && (!gen_valid_q || out_ready);

  always_ff @(posedge CK) begin
    if (RST) begin
      gen_state_q <= '0;
      gen_data_q  <= '0;
      gen_valid_q <= 1'b0;
    end else if (LOAD) begin
      // Loading the lockup state would freeze the LFSR; substitute zero.
      gen_state_q <= (SEED == LOCKUP) ? '0 : SEED;
      gen_valid_q <= 1'b0;
    end else if (gen_take) begin
      gen_state_q <= gen_state_d;
      gen_data_q  <= gen_state_d[WORD_W-1:0];
      gen_valid_q <= 1'b1;
    end else if (gen_valid_q && out_ready) begin
      gen_valid_q <= 1'b0;
    end
  end

  assign out_valid = gen_valid_q;
  assign out_data  = gen_data_q;

  // ---------------- checker ----------------
  chk_state_e        state_q, state_d;
  logic [WORD_W-1:0] w0_q, w0_d;
  logic [LFSR_W-1:0] ref_q, ref_d;
  logic [LFSR_W-1:0] ref_next;
  logic [3:0]        miss_q, miss_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              in_ready_q;
  logic              chk_take;

  prbs_step8 u_chk_step (
    .state_i (ref_q),
    .state_o (ref_next)
  );

  assign chk_take = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    ref_d   = ref_q;
    miss_d  = miss_q;
    err_d   = err_q;
    if (chk_take) begin
      case (state_q)
        SEARCH0: begin
          w0_d    = in_data;
          state_d = SEARCH1;
        end
        SEARCH1: begin
          // Two words form a full LFSR state; all-ones can never occur in a
          // real stream, so keep sliding the window until it is left behind.
          if ({w0_q, in_data} == LOCKUP) begin
            w0_d = in_data;
          end else begin
            ref_d   = {w0_q, in_data};
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          // The reference free-runs so that a corrupted word does not
          // corrupt the prediction of the following ones.
          ref_d = ref_next;
          if (in_data != ref_next[WORD_W-1:0]) begin
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
            if ((miss_q + 4'd1) == LOSS_LIM) begin
              miss_d  = '0;
              state_d = SEARCH0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH0;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= SEARCH0;
      w0_q       <= '0;
      ref_q      <= '0;
      miss_q     <= '0;
      err_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w0_q       <= w0_d;
      ref_q      <= ref_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      in_ready_q <= 1'b1;
    end
  end

  assign in_ready = in_ready_q;
  assign locked   = (state_q == LOCKED);
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: scoreboard bench for prbs_gen_chk. Stimulus pushes expected
// generator words and expected checker results into queues; a negedge monitor
// pops and compares whenever a word is transferred.
module tb_prbs_gen_chk;

  logic        CK = 1'b0;
  logic        RST, EN, LOAD, out_ready, tb_in_valid, loop;
  logic [15:0] SEED;
  logic [7:0]  tb_in_data;
  logic        out_valid, in_valid, in_ready, locked;
  logic [7:0]  out_data, in_data;
  logic [15:0] err_cnt;

  logic        flip_tbl [0:2047];
  int          xfer_idx = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  typedef struct packed {
    logic        lk;
    logic [15:0] err;
  } chk_exp_t;

  logic [7:0] exp_gen [$];
  chk_exp_t   exp_chk [$];

  always #5 CK = ~CK;

  // Loopback: the checker sees exactly the generator transfers, optionally
  // corrupted in bit 0 for selected word indices.
  assign in_valid = loop ? (out_valid & out_ready) : tb_in_valid;
  assign in_data  = loop ? (out_data ^ (flip_tbl[xfer_idx] ? 8'h01 : 8'h00)) : tb_in_data;

  always @(posedge CK) begin
    if (in_valid && in_ready) xfer_idx <= xfer_idx + 1;
  end

  prbs_gen_chk #(.LOSS_CNT(4), .ERR_W(16)) dut (
    .CK        (CK),
    .RST       (RST),
    .EN        (EN),
    .LOAD      (LOAD),
    .SEED      (SEED),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  // Bit-serial reference of eight LFSR steps.
  function automatic logic [15:0] model_step8(input logic [15:0] s_in);
    logic [15:0] s;
    logic        nb;
    s = s_in;
    for (int i = 0; i < 8; i++) begin
      nb = ~(s[15] ^ s[13] ^ s[12] ^ s[10]);
      s  = {s[14:0], nb};
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_chk(input logic lk, input logic [15:0] err);
    chk_exp_t e;
    e.lk  = lk;
    e.err = err;
    exp_chk.push_back(e);
  endtask

  // Drive one checker word directly (called at posedge+1).
  task automatic send(input logic [7:0] d, input logic lk, input logic [15:0] err);
    push_chk(lk, err);
    tb_in_valid = 1'b1;
    tb_in_data  = d;
    @(posedge CK);
    #1;
    tb_in_valid = 1'b0;
  endtask

  // Monitor / scoreboard.
  initial begin
    logic     chk_pend;
    logic [7:0] eg;
    chk_exp_t ec;
    int       gen_n;
    int       chk_n;
    chk_pend = 1'b0;
    gen_n = 0;
    chk_n = 0;
    forever begin
      @(negedge CK);
      if (RST) begin
        chk_pend = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_gen.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL gen_extra: got word %h expected no word", out_data);
          end else begin
            eg = exp_gen.pop_front();
            $display("gen  #%0d data=%h exp=%h", gen_n, out_data, eg);
            check("gen_word", 32'(out_data), 32'(eg));
          end
          gen_n++;
        end
        if (chk_pend) begin
          if (exp_chk.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL chk_extra: got result locked=%b err=%0d expected none", locked, err_cnt);
          end else begin
            ec = exp_chk.pop_front();
            $display("chk  #%0d locked=%b err=%0d exp %b/%0d", chk_n, locked, err_cnt, ec.lk, ec.err);
            check("chk_locked", 32'(locked), 32'(ec.lk));
            check("chk_err", 32'(err_cnt), 32'(ec.err));
          end
          chk_n++;
        end
        chk_pend = in_valid && in_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    logic [15:0] gm;
    logic [7:0]  m1, m2, m3;
    logic        lk;
    logic [15:0] er;

    for (int i = 0; i < 2048; i++) flip_tbl[i] = 1'b0;
    RST = 1'b1; EN = 1'b1; LOAD = 1'b0; SEED = 16'h0000; out_ready = 1'b1;
    tb_in_valid = 1'b0; tb_in_data = 8'h00; loop = 1'b0;

    // Reset state.
    repeat (2) @(posedge CK);
    @(negedge CK);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);

    // Release with downstream stalled: first word appears one cycle later and holds.
    @(posedge CK); #1;
    RST = 1'b0; out_ready = 1'b0;
    exp_gen.push_back(8'hFF);
    exp_gen.push_back(8'hE4);
    gm = 16'hFFE4;
    for (int i = 0; i < 4; i++) begin
      gm = model_step8(gm);
      exp_gen.push_back(gm[7:0]);
    end
    @(posedge CK);
    for (int i = 0; i < 5; i++) begin
      @(negedge CK);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'hFF);
    end
    @(posedge CK); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge CK);
    #1 EN = 1'b0;
    @(posedge CK);
    @(negedge CK);
    check("en_low_drop_valid", 32'(out_valid), 32'd0);

    // LOAD of the lockup seed restarts from zero and wins over EN.
    @(posedge CK); #1;
    LOAD = 1'b1; SEED = 16'hFFFF; EN = 1'b1;
    exp_gen.push_back(8'hFF);
    exp_gen.push_back(8'hE4);
    @(posedge CK); #1;
    LOAD = 1'b0;
    @(negedge CK);
    check("load_prio_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge CK);
    #1 EN = 1'b0;
    @(posedge CK);
    @(negedge CK);
    check("load_stop_valid", 32'(out_valid), 32'd0);

    // Loopback: 1000 clean words, one single error, then four in a row.
    flip_tbl[1004] = 1'b1;
    for (int i = 1010; i <= 1013; i++) flip_tbl[i] = 1'b1;
    gm = 16'h0000;
    for (int k = 0; k < 1020; k++) begin
      gm = model_step8(gm);
      exp_gen.push_back(gm[7:0]);
      if (k == 0)         begin lk = 1'b0; er = 16'd0; end
      else if (k < 1004)  begin lk = 1'b1; er = 16'd0; end
      else if (k < 1010)  begin lk = 1'b1; er = 16'd1; end
      else if (k <= 1012) begin lk = 1'b1; er = 16'(k - 1008); end
      else if (k <= 1014) begin lk = 1'b0; er = 16'd5; end
      else                begin lk = 1'b1; er = 16'd5; end
      push_chk(lk, er);
    end
    @(posedge CK); #1;
    LOAD = 1'b1; SEED = 16'h0000; EN = 1'b1; loop = 1'b1; out_ready = 1'b1;
    @(posedge CK); #1;
    LOAD = 1'b0;
    repeat (1020) @(posedge CK);
    #1 EN = 1'b0;
    repeat (3) @(posedge CK);

    // Direct checker drive: all-ones window must not lock.
    #1 loop = 1'b0; RST = 1'b1;
    @(posedge CK); #1;
    RST = 1'b0;
    @(posedge CK);
    @(negedge CK);
    check("in_ready_up", 32'(in_ready), 32'd1);
    check("chk_rst_locked", 32'(locked), 32'd0);
    gm = model_step8(16'hFFE4); m1 = gm[7:0];
    gm = model_step8(gm);       m2 = gm[7:0];
    gm = model_step8(gm);       m3 = gm[7:0];
    @(posedge CK); #1;
    send(8'hFF, 1'b0, 16'd0);
    send(8'hFF, 1'b0, 16'd0);
    @(posedge CK); #1;
    send(8'hFF, 1'b0, 16'd0);
    send(8'hE4, 1'b1, 16'd0);
    send(m1, 1'b1, 16'd0);
    send(m2, 1'b1, 16'd0);
    send(m3 ^ 8'hFF, 1'b1, 16'd1);

    // Reset while locked clears lock and error count.
    @(posedge CK); #1;
    RST = 1'b1;
    @(posedge CK);
    @(negedge CK);
    check("rst_locked_clear", 32'(locked), 32'd0);
    check("rst_err_clear", 32'(err_cnt), 32'd0);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge CK); #1;
    RST = 1'b0;
    repeat (2) @(posedge CK);

    check("gen_queue_drained", 32'(exp_gen.size()), 32'd0);
    check("chk_queue_drained", 32'(exp_chk.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
